// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and one-hot decode for the round-robin
// arbiter and the downstream 16-to-4 encoder's checker.
package arb_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    // OR-encodes the set bit; meaningful only for zero or one-hot input.
    function automatic logic [IDX_W-1:0] oh_to_idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_onehot_arbiter_if #(
    parameter int N = 16
);
    logic [N-1:0] req;
    logic         ack;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic         timeout;

    modport master (
        output req,
        output ack,
        input  grant,
        input  grant_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  ack,
        output grant,
        output grant_valid,
        output timeout
    );
endinterface

// File: rtl/rr_onehot_arbiter_pick.sv
// Combinational rotate-priority picker: first set request at or above ptr_i,
// wrapping from N-1 back to 0, returned as a one-hot winner.
module rr_pick #(
    parameter int N     = 16,
    parameter int PTR_W = 4
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     winner_o,
    output logic             any_req_o
);

    int               pos;
    logic [PTR_W-1:0] pos_idx;
    logic             found;

    assign any_req_o = |req_i;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        pos      = 0;
        pos_idx  = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= N) pos = pos - N;
            pos_idx = PTR_W'(pos);
            if (!found && req_i[pos_idx]) begin
                winner_o[pos_idx] = 1'b1;
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter issuing a registered one-hot grant with a release bubble.
// Optional forced revocation after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_onehot_arbiter
    import arb_pkg::*;
#(
    parameter int N        = N_REQ,
    parameter int MAX_HOLD = 64
) (
    input  logic              clk,
    input  logic              rst,
    rr_onehot_arbiter_if.slave bus
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    if (N < 2 || N > N_REQ) begin : g_bad_n
        $error("rr_onehot_arbiter: N must be in 2..16");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_bad_hold
        $error("rr_onehot_arbiter: MAX_HOLD must be in 2..65535");
    end

    state_t           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     winner;
    logic             any_req;
    logic [PTR_W-1:0] granted_idx, next_ptr;
    logic             do_release;

    rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
        .req_i     (bus.req),
        .ptr_i     (ptr_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    assign granted_idx = PTR_W'(oh_to_idx(N_REQ'(grant_q)));
    assign next_ptr    = (granted_idx == PTR_W'(N - 1)) ? '0 : granted_idx + PTR_W'(1);
    // Grant is one-hot in GRANT, so the masked OR is req[granted].
    assign do_release  = bus.ack || !(|(bus.req & grant_q));

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    grant_d = winner;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            GRANT: begin
                if (do_release) begin
                    state_d = RELEASE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                    state_d   = RELEASE;
                    grant_d   = '0;
                    ptr_d     = next_ptr;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
`endif
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.grant       = grant_q;
    assign bus.grant_valid = |grant_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench for rr_onehot_arbiter: directed plan plus randomized
// traffic compared against a behavioural round-robin model.
module tb_rr_onehot_arbiter;

    localparam int N        = 16;
    localparam int MAX_HOLD = 4;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    rr_onehot_arbiter_if #(.N(N)) bus ();

    rr_onehot_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner index (-1 = none), bubble flag, pointer, cycles held.
    int m_owner  = -1;
    int m_bubble = 0;
    int m_ptr    = 0;
    int m_held   = 0;
    bit m_to     = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input logic [N-1:0] rq, input bit ak);
        bit found;
        int c;
        if (r) begin
            m_owner = -1; m_bubble = 0; m_ptr = 0; m_held = 0; m_to = 1'b0;
        end else if (m_owner >= 0) begin
            m_to   = 1'b0;
            m_held = m_held + 1;
            if (ak || !rq[m_owner]) begin
                m_ptr = (m_owner + 1) % N; m_owner = -1; m_bubble = 1;
            end
`ifdef ARB_TIMEOUT_EN
            else if (m_held == MAX_HOLD) begin
                m_ptr = (m_owner + 1) % N; m_owner = -1; m_bubble = 1; m_to = 1'b1;
            end
`endif
        end else if (m_bubble != 0) begin
            m_bubble = 0; m_to = 1'b0;
        end else begin
            m_to  = 1'b0;
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!found && rq[c]) begin
                    found = 1'b1; m_owner = c; m_held = 0;
                end
            end
        end
    endtask

    task automatic step();
        logic [N-1:0] exp_grant;
        @(posedge clk);
        model_edge(rst, bus.req, bus.ack);
        @(negedge clk);
        exp_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        check("model_grant", bus.grant, exp_grant);
        check("model_valid", bus.grant_valid, (m_owner >= 0));
        check("model_timeout", bus.timeout, m_to);
        check("onehot0", $onehot0(bus.grant), 1);
    endtask

    task automatic wait_grant(input int budget);
        for (int i = 0; i < budget && !bus.grant_valid; i++) step();
        check("wait_grant", bus.grant_valid, 1);
    endtask

    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.ack = 1'b0;
        step();
        step();
        check("rst_grant", bus.grant, 16'h0000);
        check("rst_valid", bus.grant_valid, 0);

        // Idle with no requests
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_grant", bus.grant, 16'h0000);
        end

        // Lowest set bit at or above ptr=0 wins; two-cycle gap before the next grant
        bus.req = 16'h0090;
        step();
        check("p2_first", bus.grant, 16'h0010);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        check("p2_gap1", bus.grant, 16'h0000);
        step();
        check("p2_gap2", bus.grant, 16'h0000);
        step();
        check("p2_second", bus.grant, 16'h0080);

        // Full rotation with wrap, starting from a fresh pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req = 16'hFFFF;
        for (int i = 0; i < 17; i++) begin
            wait_grant(6);
            check("rotate", bus.grant, 16'h0001 << (i % 16));
            bus.ack = 1'b1;
            step();
            bus.ack = 1'b0;
        end

        // Withdrawal without ack releases and moves ptr to 4
        bus.req = 16'h0008;
        wait_grant(6);
        check("wd_grant", bus.grant, 16'h0008);
        bus.req = 16'h0000;
        step();
        check("wd_drop", bus.grant, 16'h0000);
        check("wd_valid", bus.grant_valid, 0);
        bus.req = 16'h0009;
        step();
        step();
        check("wd_next", bus.grant, 16'h0001);

        // Reset mid-grant
        rst = 1'b1;
        step();
        check("midrst_grant", bus.grant, 16'h0000);
        check("midrst_valid", bus.grant_valid, 0);
        rst = 1'b0;
        bus.req = 16'h8001;
        step();
        check("postrst_grant", bus.grant, 16'h0001);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        bus.req = '0;
        step();
        step();

`ifdef ARB_TIMEOUT_EN
        bus.req = 16'h0004;
        wait_grant(6);
        check("to_grant", bus.grant, 16'h0004);
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            step();
            check("to_held", bus.grant, 16'h0004);
        end
        step();
        check("to_drop", bus.grant, 16'h0000);
        check("to_pulse", bus.timeout, 1);
        step();
        check("to_pulse_end", bus.timeout, 0);
        step();
        check("to_regrant", bus.grant, 16'h0004);
        bus.req = '0;
        step();
        step();
`endif

        // Randomized traffic, including ack outside GRANT and occasional reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0:       bus.req = '0;
                    1:       bus.req = N'(1) << $urandom_range(0, N - 1);
                    2:       bus.req = N'($urandom);
                    default: bus.req = N'($urandom) & N'($urandom);
                endcase
            end
            bus.ack = ($urandom_range(0, 3) == 0);
            rst     = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Sequential round-robin arbiter directly upstream of the 16-to-4 one-hot encoder in the ALU converter path.
- Takes up to 16 request lines and issues exactly one registered one-hot grant, which the encoder turns into a 4-bit index.
- Holds the grant until the requester acknowledges or withdraws, then rotates priority so no requester starves.

Parameters:
- N, 16, number of requesters. The encoder downstream is fixed at 16; other values are for unit test only.
- MAX_HOLD, 64, maximum grant-hold cycles. Used only when ARB_TIMEOUT_EN is defined; legal range 2..65535.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  N  request vector; bit i = requester i wants service
- ack  input  1  single-cycle release pulse from the granted requester
- grant  output  N  registered one-hot grant; all-zero when idle
- grant_valid  output  1  high whenever grant is non-zero
- timeout  output  1  one-cycle pulse on forced revocation; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: grant=0, grant_valid=0, timeout=0, state=IDLE, priority pointer ptr=0, hold counter=0.
- Reset mid-grant: all of the above are forced on the next edge with rst high. Grant drops with no ack needed.
- Three FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If req is non-zero, select the first asserted bit scanning upward from ptr, wrapping N-1 to 0.
  - Next edge: grant = one-hot of winner, grant_valid=1, go to GRANT.
  - Latency is exactly 1 cycle from the req sample to grant.
  - If req is zero, stay in IDLE with grant=0.
- GRANT:
  - Grant is held stable; it never changes while in this state.
  - Release condition: ack=1 OR req[granted]=0, sampled at the clock edge.
  - On release, next edge: grant=0, grant_valid=0, ptr=(granted index+1) mod N, go to RELEASE.
  - ack and req drop in the same cycle count as a single release.
  - ack while in IDLE or RELEASE is ignored.
- RELEASE:
  - One mandatory bubble cycle with grant=0, then go to IDLE unconditionally.
  - Guarantees the encoder sees zero between grants.
  - Back-to-back grants are therefore spaced by at least 2 cycles of grant=0: RELEASE + IDLE sample.
- Invariant: grant is always zero or exactly one-hot. Never multi-hot, in any state or under any req pattern.
- ptr wraps: index 15 released gives ptr=0.
- req changing during GRANT has no effect until the release condition.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on entry to GRANT and increments each GRANT cycle.
  - If it reaches MAX_HOLD with no release, the next edge forces the release path (grant=0, ptr advances, RELEASE) and pulses timeout for that one cycle.
  - A normal release on the same cycle as the limit takes priority; no timeout pulse.
- Not defined: no counter logic; timeout tied to 0; grants are held indefinitely.

Decomposition:
- Package arb_pkg holds:
  - N_REQ=16 and IDX_W=4 constants
  - the state enum {IDLE, GRANT, RELEASE}
  - a onehot-to-index function shared with the encoder's checker
- One natural sub-module, rr_pick: combinational rotate-priority picker.
  - Inputs: req and ptr.
  - Outputs: one-hot winner and any_req.
  - The top holds the FSM, ptr, grant register and timeout counter.

Test Plan:
- Reset then req=16'h0000 for 10 cycles -> grant=0, grant_valid=0 throughout.
- req=16'h0090, ptr=0 -> grant=16'h0010 one cycle later. Pulse ack -> grant=0 for 2 cycles, then grant=16'h0080.
- req=16'hFFFF held, ack pulsed each time grant appears -> grants cycle 0x0001, 0x0002, ... 0x8000, then 0x0001 again (wrap check). Every grant is one-hot.
- Grant to bit 3, then req[3] deasserted without ack -> grant=0 next cycle, ptr=4. With req=16'h0009, next grant is 16'h0001.
- Assert rst mid-GRANT -> grant=0, grant_valid=0 on the next edge. After rst is released with req=16'h8001 -> grant=16'h0001 (ptr reset to 0).
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=16'h0004, no ack -> grant held 4 cycles, then grant=0 with a one-cycle timeout pulse. Regrant 16'h0004 after the bubble.
